// File: rtl/arch_defs.sv
// Shared architectural definitions for the IF/ID boundary.
package arch_defs;

    localparam int XLEN   = 32;
    localparam int PAIR_W = 2 * XLEN;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // One captured fetch: PC in the upper half, instruction in the lower half.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_queue_regfile.sv
// Storage array for the fetch queue: synchronous write, asynchronous read.
// Entries are not reset; the owner tracks which slots hold valid data.
module fetch_queue_regfile #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Capture the write data into the addressed slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling queue: accepts {PC, instruction} pairs from fetch,
// presents them in order to decode, back-pressures fetch via freeze and
// discards all held entries on a taken branch.
module if_id_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int XLEN  = arch_defs::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_instruction,
    input  logic            branch_taken,
    output logic            freeze,
    input  logic            id_stall,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instruction,
    output logic [AW:0]     occupancy
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE        = (AW+1)'(1);

    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] wdata;
    logic [2*XLEN-1:0] rdata;

    // Handshake decode: flush overrides everything, full blocks the push.
    always_comb begin
        freeze   = (count == FULL_COUNT) & ~branch_taken;
        id_valid = (count != '0);
        push     = ~freeze & ~branch_taken;
        pop      = id_valid & ~id_stall & ~branch_taken;
    end

    assign wdata = {if_pc, if_instruction};

    fetch_queue_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (2*XLEN)
    ) u_regfile (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Pointer and count update; a flush rewinds both pointers to slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Head presentation: NOP with zero PC whenever the queue is empty.
    always_comb begin
        id_pc          = '0;
        id_instruction = XLEN'(arch_defs::NOP_INSTR);
        if (id_valid) begin
            id_pc          = rdata[2*XLEN-1:XLEN];
            id_instruction = rdata[XLEN-1:0];
        end
    end

    assign occupancy = count;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue: a table of per-cycle vectors plus
// hand-written wrap and asynchronous-reset sequences.
module tb_if_id_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        branch_taken;
    logic        freeze;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic [2:0]  occupancy;

    int n_vec;
    int n_err;

    if_id_fetch_queue #(
        .DEPTH (4),
        .AW    (2),
        .XLEN  (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .branch_taken   (branch_taken),
        .freeze         (freeze),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return ~pc ^ 32'h1357_9BDF;
    endfunction

    assign if_instruction = instr_of(if_pc);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs and the outputs expected during the cycle they are applied.
    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        br;
        logic        frz;
        logic        val;
        logic [31:0] idpc;
        logic [2:0]  occ;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic [31:0] pc, input logic stall, input logic br,
                                input logic frz, input logic val, input logic [31:0] idpc,
                                input logic [2:0] occ);
        vec_t v;
        v.pc = pc; v.stall = stall; v.br = br;
        v.frz = frz; v.val = val; v.idpc = idpc; v.occ = occ;
        return v;
    endfunction

    task automatic apply_and_check(input vec_t v, input int idx);
        if_pc        = v.pc;
        id_stall     = v.stall;
        branch_taken = v.br;
        #1;
        check($sformatf("vec%0d_freeze", idx), 64'(freeze), 64'(v.frz));
        check($sformatf("vec%0d_valid", idx), 64'(id_valid), 64'(v.val));
        check($sformatf("vec%0d_pc", idx), 64'(id_pc), 64'(v.idpc));
        check($sformatf("vec%0d_instr", idx), 64'(id_instruction),
              64'(v.val ? instr_of(v.idpc) : 32'h0));
        check($sformatf("vec%0d_occ", idx), 64'(occupancy), 64'(v.occ));
        @(posedge clk);
        #1;
    endtask

    task automatic flush_cycle();
        branch_taken = 1'b1;
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        int          popped;
        logic        advance;

        n_vec = 0;
        n_err = 0;

        // Stream with no stall
        tbl[0]  = mk(32'h00, 0, 0, 0, 0, 32'h00, 3'd0);
        tbl[1]  = mk(32'h04, 0, 0, 0, 1, 32'h00, 3'd1);
        tbl[2]  = mk(32'h08, 0, 0, 0, 1, 32'h04, 3'd1);
        tbl[3]  = mk(32'h0C, 0, 0, 0, 1, 32'h08, 3'd1);
        tbl[4]  = mk(32'h10, 0, 1, 0, 1, 32'h0C, 3'd1);
        // Fill from empty with decode stalled
        tbl[5]  = mk(32'h00, 1, 0, 0, 0, 32'h00, 3'd0);
        tbl[6]  = mk(32'h04, 1, 0, 0, 1, 32'h00, 3'd1);
        tbl[7]  = mk(32'h08, 1, 0, 0, 1, 32'h00, 3'd2);
        tbl[8]  = mk(32'h0C, 1, 0, 0, 1, 32'h00, 3'd3);
        tbl[9]  = mk(32'h10, 1, 0, 1, 1, 32'h00, 3'd4);
        tbl[10] = mk(32'h10, 1, 0, 1, 1, 32'h00, 3'd4);
        // Release: freeze drops one cycle after the first pop
        tbl[11] = mk(32'h10, 0, 0, 1, 1, 32'h00, 3'd4);
        tbl[12] = mk(32'h10, 0, 0, 0, 1, 32'h04, 3'd3);
        tbl[13] = mk(32'h14, 0, 0, 0, 1, 32'h08, 3'd3);
        tbl[14] = mk(32'h18, 0, 0, 0, 1, 32'h0C, 3'd3);
        tbl[15] = mk(32'h1C, 0, 0, 0, 1, 32'h10, 3'd3);
        // Refill to 4, then flush while full
        tbl[16] = mk(32'h20, 1, 0, 0, 1, 32'h14, 3'd3);
        tbl[17] = mk(32'h24, 1, 1, 0, 1, 32'h14, 3'd4);
        tbl[18] = mk(32'h40, 0, 0, 0, 0, 32'h00, 3'd0);
        tbl[19] = mk(32'h44, 0, 0, 0, 1, 32'h40, 3'd1);
        // Build to 2, then simultaneous push and pop
        tbl[20] = mk(32'h48, 1, 0, 0, 1, 32'h44, 3'd1);
        tbl[21] = mk(32'h4C, 0, 0, 0, 1, 32'h44, 3'd2);
        tbl[22] = mk(32'h50, 0, 0, 0, 1, 32'h48, 3'd2);
        tbl[23] = mk(32'h54, 0, 0, 0, 1, 32'h4C, 3'd2);

        rst          = 1'b1;
        if_pc        = '0;
        id_stall     = 1'b0;
        branch_taken = 1'b0;

        // Reset values appear before any clock edge.
        #3;
        check("reset_valid", 64'(id_valid), 64'd0);
        check("reset_freeze", 64'(freeze), 64'd0);
        check("reset_occ", 64'(occupancy), 64'd0);
        check("reset_pc", 64'(id_pc), 64'd0);
        check("reset_instr", 64'(id_instruction), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply_and_check(tbl[i], i);
        end

        // Wrap: fetch advances only when not frozen; decode stall toggles.
        flush_cycle();
        pc     = 32'h100;
        popped = 0;
        for (int c = 0; c < 80 && popped < 10; c++) begin
            id_stall = c[0];
            if_pc    = pc;
            #1;
            if (id_valid && !id_stall) begin
                check($sformatf("wrap_order%0d", popped), 64'(id_pc), 64'(32'h100 + 32'(4 * popped)));
                check($sformatf("wrap_instr%0d", popped), 64'(id_instruction),
                      64'(instr_of(32'h100 + 32'(4 * popped))));
                popped++;
            end
            check("wrap_freeze_full", 64'(freeze), 64'(occupancy == 3'd4));
            advance = !freeze;
            @(posedge clk);
            #1;
            if (advance) pc = pc + 32'd4;
        end
        check("wrap_popped_count", 64'(popped), 64'd10);

        // Asynchronous reset at occupancy 3.
        flush_cycle();
        id_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if_pc = 32'h300 + 32'(4 * k);
            @(posedge clk);
            #1;
        end
        check("areset_pre_occ", 64'(occupancy), 64'd3);
        if_pc = 32'h30C;
        #2;
        rst = 1'b1;
        #1;
        check("areset_valid", 64'(id_valid), 64'd0);
        check("areset_freeze", 64'(freeze), 64'd0);
        check("areset_occ", 64'(occupancy), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        id_stall = 1'b0;
        apply_and_check(mk(32'h200, 0, 0, 0, 0, 32'h000, 3'd0), 100);
        apply_and_check(mk(32'h204, 0, 0, 0, 1, 32'h200, 3'd1), 101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
